// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader front-end.
// The loader streams unpacked pixels to the core and returns the classified digit.
package snn_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_CORE,
        TX,
        WAIT_TX
    } loader_state_t;

    localparam int unsigned NUM_PIXELS = 784;
    localparam logic [7:0]  ASCII_BASE = 8'h30;
    localparam logic [7:0]  ASCII_ERR  = 8'h3F;

    // Digits above 9 cannot come from a valid classification, so they map to '?'.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit,
                                                  input logic [7:0] base);
        return (digit <= 4'd9) ? base + {4'd0, digit} : ASCII_ERR;
    endfunction

endpackage

// File: rtl/snn_image_loader_if.sv
// Bundle of the loader's UART, input-RAM, core and status signals.
// The master side is the loader; the slave side is its surrounding system.
interface snn_image_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_data;
    logic              ram_we;
    logic              start;
    logic              core_done;
    logic [3:0]        core_digit;
    logic [7:0]        tx_data;
    logic              trmt;
    logic              tx_done;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_rdy, rx_data, core_done, core_digit, tx_done,
        output ram_addr, ram_data, ram_we, start, tx_data, trmt, busy, overrun
    );

    modport slave (
        output rx_rdy, rx_data, core_done, core_digit, tx_done,
        input  ram_addr, ram_data, ram_we, start, tx_data, trmt, busy, overrun
    );
endinterface

// File: rtl/snn_image_loader_pixel_unpacker.sv
// Byte-to-bit unpacker with a one-deep skid register and sticky overrun.
// flush clears all pending work; any byte held or arriving during flush counts as dropped.
module pixel_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_stb,
    input  logic       flush,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       overrun
);
    logic [7:0] shift_q;
    logic [7:0] skid_q;
    logic       skid_full;
    logic       active;
    logic [2:0] cnt;
    logic       last_bit;

    assign last_bit  = active && (cnt == 3'd7);
    assign bit_out   = shift_q[0];
    assign bit_valid = active;
    assign busy      = active || skid_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            skid_q    <= '0;
            skid_full <= 1'b0;
            active    <= 1'b0;
            cnt       <= '0;
            overrun   <= 1'b0;
        end else if (flush) begin
            active    <= 1'b0;
            skid_full <= 1'b0;
            cnt       <= '0;
            if (skid_full || byte_stb)
                overrun <= 1'b1;
        end else if (!active || last_bit) begin
            // Free slot this edge: the skid byte wins, a fresh byte loads directly otherwise.
            cnt <= '0;
            if (skid_full) begin
                shift_q   <= skid_q;
                active    <= 1'b1;
                skid_full <= 1'b0;
                if (byte_stb)
                    overrun <= 1'b1;
            end else if (byte_stb) begin
                shift_q <= byte_in;
                active  <= 1'b1;
            end else begin
                active  <= 1'b0;
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end else begin
            shift_q <= {1'b0, shift_q[7:1]};
            cnt     <= cnt + 3'd1;
            if (byte_stb) begin
                if (skid_full) begin
                    overrun <= 1'b1;
                end else begin
                    skid_q    <= byte_in;
                    skid_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/snn_image_loader.sv
// Image loader: fills the core's input RAM from UART bytes, starts the core,
// and sends the resulting digit back as ASCII.
module snn_image_loader #(
    parameter int unsigned NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W     = 10,
    parameter logic [7:0]  ASCII_BASE = snn_pkg::ASCII_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    snn_image_loader_if.master    bus
);
    import snn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr_q;
    logic              start_q;
    logic              trmt_q;
    logic [7:0]        tx_data_q;
    logic              bit_out;
    logic              bit_valid;
    logic              unp_busy;
    logic              unp_overrun;
    logic              last_write;
    logic              flush;

    // Outside LOAD the unpacker is held flushed, so stray rx bytes register as overrun.
    assign last_write = (state == LOAD) && bit_valid && (addr_q == LAST_ADDR);
    assign flush      = (state != LOAD) || last_write;

    pixel_unpacker u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (bus.rx_data),
        .byte_stb  (bus.rx_rdy),
        .flush     (flush),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (unp_busy),
        .overrun   (unp_overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            addr_q    <= '0;
            start_q   <= 1'b0;
            trmt_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            start_q <= 1'b0;
            trmt_q  <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (bit_valid) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (addr_q == LAST_ADDR) begin
                            state   <= START;
                            start_q <= 1'b1;
                        end
                    end
                end
                START: state <= WAIT_CORE;
                WAIT_CORE: begin
                    if (bus.core_done) begin
                        tx_data_q <= digit_to_ascii(bus.core_digit, ASCII_BASE);
                        trmt_q    <= 1'b1;
                        state     <= TX;
                    end
                end
                TX: state <= WAIT_TX;
                WAIT_TX: begin
                    if (bus.tx_done) begin
                        addr_q <= '0;
                        state  <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_data = bit_out;
    assign bus.ram_we   = bit_valid;
    assign bus.start    = start_q;
    assign bus.trmt     = trmt_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state != LOAD) || unp_busy;
    assign bus.overrun  = unp_overrun;

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: a cycle-level reference model predicts
// every RAM write, start pulse and transmit byte; a negedge monitor checks them.
module tb_snn_image_loader;

    localparam int NP = 784;
    localparam int NB = NP / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_image_loader_if #(.ADDR_W(10)) bus ();

    snn_image_loader #(
        .NUM_PIXELS (NP),
        .ADDR_W     (10),
        .ASCII_BASE (8'h30)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int cyc; int addr; logic data; } wr_t;
    typedef struct { int cyc; logic [7:0] val; } tx_t;

    wr_t wq[$];
    int  sq[$];
    tx_t tq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state for the image currently being loaded
    int         img_bytes  = 0;
    int         last_start = -1;
    int         last_end   = -1;
    bit         exp_ovr    = 1'b0;
    logic [7:0] held_tx    = 8'h00;
    int         exp_starts = 0;
    int         exp_trmts  = 0;
    int         start_cnt  = 0;
    int         trmt_cnt   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_ascii(input int d);
        if (d <= 9) return 8'(48 + d);
        return 8'h3F;
    endfunction

    // A byte offered at cycle c: dropped if the image is full or a byte is already
    // waiting to start; otherwise its 8 pixels follow the previous byte back-to-back.
    function automatic void model_rx(input int c, input logic [7:0] b);
        int s;
        if (img_bytes >= NB || last_start > c) begin
            exp_ovr = 1'b1;
        end else begin
            s = (c + 1 > last_end + 1) ? c + 1 : last_end + 1;
            for (int i = 0; i < 8; i++)
                wq.push_back('{s + i, img_bytes * 8 + i, b[i]});
            last_start = s;
            last_end   = s + 7;
            img_bytes++;
            if (img_bytes == NB) begin
                sq.push_back(last_end + 1);
                exp_starts++;
            end
        end
    endfunction

    function automatic void model_new_image();
        img_bytes  = 0;
        last_start = -1;
        last_end   = -1;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_rx(cyc, b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_data"}, bus.ram_data, 0);
        chk({tag, "_ram_we"},   bus.ram_we,   0);
        chk({tag, "_start"},    bus.start,    0);
        chk({tag, "_trmt"},     bus.trmt,     0);
        chk({tag, "_tx_data"},  bus.tx_data,  0);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_overrun"},  bus.overrun,  0);
    endtask

    task automatic do_reset();
        bus.rx_rdy    = 1'b0;
        bus.core_done = 1'b0;
        bus.tx_done   = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wq.delete();
        sq.delete();
        tq.delete();
        model_new_image();
        exp_ovr = 1'b0;
        held_tx = 8'h00;
        exp_starts = start_cnt;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    // Waits for start, answers with digit d, then completes the UART transmit.
    // Returns at the negedge of the first LOAD cycle so a byte can follow at once.
    task automatic core_phase(input int d, input bit stray_rx);
        for (int i = 0; i < 5000 && start_cnt < exp_starts; i++) wait_cycles(1);
        chk("start_seen", start_cnt, exp_starts);
        wait_cycles(2 + $urandom_range(0, 3));
        if (stray_rx) begin
            send_byte(8'($urandom));
            wait_cycles(1);
        end
        chk("wait_core_busy", bus.busy, 1);
        chk("overrun_sticky", bus.overrun, exp_ovr);
        bus.core_digit = 4'(d);
        bus.core_done  = 1'b1;
        tq.push_back('{cyc + 1, exp_ascii(d)});
        exp_trmts++;
        wait_cycles(1);
        bus.core_done  = 1'b0;
        for (int i = 0; i < 100 && trmt_cnt < exp_trmts; i++) wait_cycles(1);
        chk("trmt_seen", trmt_cnt, exp_trmts);
        wait_cycles($urandom_range(1, 4));
        bus.tx_done = 1'b1;
        wait_cycles(1);
        bus.tx_done = 1'b0;
        model_new_image();
        @(negedge clk);
        chk("load_idle_busy", bus.busy, 0);
        chk("load_addr_zero", bus.ram_addr, 0);
    endtask

    wr_t mon_w;
    tx_t mon_t;
    int  mon_s;

    always @(negedge clk) begin
        if (rst_n) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                mon_w = wq.pop_front();
                chk("write_missing_cycle", cyc, mon_w.cyc);
            end
            if (bus.ram_we) begin
                if (wq.size() == 0) begin
                    chk("write_expected", wq.size(), 1);
                end else begin
                    mon_w = wq.pop_front();
                    chk("write_cycle", cyc, mon_w.cyc);
                    chk("write_addr", bus.ram_addr, mon_w.addr);
                    chk("write_data", bus.ram_data, mon_w.data);
                end
            end
            if (bus.start) begin
                start_cnt++;
                if (sq.size() == 0) begin
                    chk("start_expected", sq.size(), 1);
                end else begin
                    mon_s = sq.pop_front();
                    chk("start_cycle", cyc, mon_s);
                end
            end
            if (bus.trmt) begin
                trmt_cnt++;
                if (tq.size() == 0) begin
                    chk("trmt_expected", tq.size(), 1);
                end else begin
                    mon_t = tq.pop_front();
                    chk("trmt_cycle", cyc, mon_t.cyc);
                    held_tx = mon_t.val;
                end
            end
            chk("tx_data", bus.tx_data, held_tx);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bus.rx_rdy     = 1'b0;
        bus.rx_data    = 8'h00;
        bus.core_done  = 1'b0;
        bus.core_digit = 4'h0;
        bus.tx_done    = 1'b0;
        #2;
        check_reset_outputs("reset");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);

        // Image 1: A5 first, then bytes at +2 and +4 (third overflows the skid).
        send_byte(8'hA5);
        wait_cycles(1);
        send_byte(8'($urandom));
        wait_cycles(1);
        b = 8'($urandom);
        model_rx(cyc, b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        @(negedge clk);
        chk("overrun_before_drop", bus.overrun, 0);
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        chk("overrun_after_drop", bus.overrun, 1);
        @(posedge clk);
        #1;
        while (img_bytes < NB) begin
            send_byte(8'($urandom));
            wait_cycles($urandom_range(0, 12));
        end
        send_byte(8'($urandom));
        core_phase(7, 1'b1);

        // Image 2: all-ones bytes spaced 20 cycles apart.
        for (int k = 0; k < NB; k++) begin
            send_byte(8'hFF);
            wait_cycles(19);
        end
        core_phase(12, 1'b0);

        // Image 3: 01 right after tx_done, stray core/tx strobes, reset after 40 bytes.
        send_byte(8'h01);
        while (img_bytes < 40) begin
            if (img_bytes == 20) begin
                bus.core_done  = 1'b1;
                bus.core_digit = 4'd3;
                bus.tx_done    = 1'b1;
                wait_cycles(1);
                bus.core_done  = 1'b0;
                bus.tx_done    = 1'b0;
            end
            send_byte(8'($urandom));
            wait_cycles($urandom_range(0, 6));
        end
        wait_cycles($urandom_range(0, 8));
        do_reset();

        // Image 4: full random image after the mid-operation reset.
        while (img_bytes < NB) begin
            send_byte(8'($urandom));
            wait_cycles($urandom_range(0, 10));
        end
        core_phase(int'($urandom_range(0, 15)), 1'b0);

        wait_cycles(20);
        chk("queues_drained", wq.size() + sq.size() + tq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_image_loader.md
# snn_image_loader

Front-end feeder for the SNN digit classifier. Takes UART-received bytes, unpacks each into eight 1-bit pixels, and writes them sequentially into the input-unit RAM that the core reads. After the last pixel it pulses the core's start, waits for done, latches the digit, and transmits it over UART as ASCII. It is the writer/initiator paired with the core's reader side of the input RAM and start/done handshake.

## Interface
- NUM_PIXELS, 784: pixels per image; must be a multiple of 8.
- ADDR_W, 10: input RAM address width.
- ASCII_BASE, 8'h30: added to the digit for transmission.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_rdy  in  1  one-cycle strobe: rx_data valid.
- rx_data  in  8  received byte; bit0 is the first pixel.
- ram_addr  out  ADDR_W  input RAM write address.
- ram_data  out  1  pixel bit.
- ram_we  out  1  write enable.
- start  out  1  one-cycle pulse to the core.
- core_done  in  1  core completion strobe.
- core_digit  in  4  classified digit; valid when core_done=1.
- tx_data  out  8  byte to the UART transmitter.
- trmt  out  1  one-cycle transmit request.
- tx_done  in  1  transmitter finished strobe.
- busy  out  1  high in any state except LOAD-idle (no byte pending or unpacking).
- overrun  out  1  sticky; a received byte was dropped.

## Operation
- States: LOAD, START, WAIT_CORE, TX, WAIT_TX. Reset state is LOAD.
- LOAD:
  - rx_rdy captures rx_data into the shift register if the unpacker is idle, otherwise into a 1-deep skid register.
  - If the skid register is already full, the byte is dropped and overrun is set.
  - The unpacker writes one bit per cycle, LSB first: bit i of byte k goes to address 8k+i.
  - ram_addr increments after each write.
  - When the skid register holds a byte at the last bit of the current byte, that byte begins unpacking the next cycle with no bubble.
- The write to address NUM_PIXELS-1 transitions to START.
- Any byte in the skid register at that point is discarded and sets overrun.
- START: start=1 for exactly one cycle, then WAIT_CORE.
- WAIT_CORE: on core_done, latch core_digit and go to TX.
- TX: trmt=1 for one cycle; tx_data = ASCII_BASE + digit if digit ≤ 9, else 8'h3F. Then WAIT_TX.
- WAIT_TX: on tx_done, ram_addr←0 and return to LOAD.
- rx_rdy in any state other than LOAD drops the byte and sets overrun.
- overrun clears only on reset.
- ram_data is driven from the shift register LSB; it is don't-care when ram_we=0.

## Timing
- Reset values: ram_addr=0, ram_data=0, ram_we=0, start=0, trmt=0, tx_data=0, busy=0, overrun=0; state LOAD; shift and skid registers empty.
- rx_rdy at cycle n with unpacker idle: ram_we=1 during cycles n+1..n+8, addresses 8k..8k+7.
- start is asserted the cycle after the final write.
- A core_done at cycle m gives trmt=1 at cycle m+1; tx_data stays stable from m+1 until the next TX.
- A tx_done at cycle p returns to LOAD at p+1. An rx_rdy at p+1 is accepted.
- core_done or tx_done outside its wait state is ignored.
- Reset asserted mid-operation returns all state and outputs to reset values immediately; the next image starts at address 0.
- All registered outputs change only on clk rising edges. No combinational path from any input to any output.

## Structure
- Shared package snn_pkg:
  - loader_state_t enum (LOAD, START, WAIT_CORE, TX, WAIT_TX)
  - NUM_PIXELS
  - ASCII_BASE
  - ASCII_ERR = 8'h3F
- Sub-module pixel_unpacker: shift register, skid register, 3-bit bit counter, overrun detect. Interface: byte in/strobe, bit out/valid, busy, flush.
- Top level holds the FSM, address counter, digit latch and TX logic.

## Test plan
- 98 bytes of 8'hFF, each with rx_rdy spaced 20 cycles apart -> 784 writes with ram_data=1, addresses 0..783 contiguous; start is a single pulse one cycle after the write to 783.
- First byte 8'hA5 -> addresses 0..7 written with data 1,0,1,0,0,1,0,1.
- rx_rdy on cycles 0, 2, 4 while idle:
  - bytes 1 and 2 are written on cycles 1..16 with no gap;
  - byte 3 is dropped and overrun=1 from cycle 5 onward.
- core_done with core_digit=7 -> trmt=1 next cycle, tx_data=8'h37.
- Repeat with core_digit=12 -> tx_data=8'h3F.
- tx_done after TX; next byte 8'h01 -> write to address 0 with data 1, then addresses 1..7 with data 0.
- rst_n pulsed low after 40 bytes -> all outputs at reset values; a full 98-byte image afterward produces addresses 0..783 and one start pulse.
